// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : op encodings and shared FSM state type for the ALU function units
// Rev 1.0
// ============================================================================
package alu_pkg;

   localparam logic [1:0] ALU_SLL = 2'b00;
   localparam logic [1:0] ALU_SRL = 2'b01;
   localparam logic [1:0] ALU_ROR = 2'b10;
   localparam logic [1:0] ALU_SRA = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// ============================================================================
// alu_shift_step : combinational shift of XLEN bits by k in [0, STEP] per op
// Rev 1.0
// ============================================================================
module alu_shift_step
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 4,
   parameter int KW   = $clog2(STEP + 1)
) (
   input  logic [1:0]      op_i,
   input  logic [KW-1:0]   k_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] w_stage [KW+1];

   assign w_stage[0] = data_i;

   // Stage j moves by 2**j; stage amount may equal XLEN when STEP == XLEN.
   for (genvar j = 0; j < KW; j++) begin : g_stage
      localparam int S = 1 << j;
      logic [XLEN-1:0] w_sh;

      always_comb begin
         case (op_i)
            ALU_SLL: w_sh = w_stage[j] << S;
            ALU_SRL: w_sh = w_stage[j] >> S;
            ALU_SRA: w_sh = $signed(w_stage[j]) >>> S;
            default: w_sh = (w_stage[j] >> S) | (w_stage[j] << (XLEN - S));
         endcase
      end

      assign w_stage[j+1] = k_i[j] ? w_sh : w_stage[j];
   end

   assign data_o = w_stage[KW];

endmodule
`default_nettype wire

// File: rtl/alu_shift_seq.sv
`default_nettype none
// ============================================================================
// alu_shift_seq : multi-cycle SLL/SRL/SRA/ROR unit, up to STEP bits per clock
// Rev 1.0
// ============================================================================
module alu_shift_seq
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam int KW  = $clog2(STEP + 1);

   alu_state_e      state_q;
   logic [1:0]      op_q;
   logic [XLEN-1:0] work_q;
   logic [XLEN-1:0] work_d;
   logic [XLEN-1:0] rd_q;
   logic [SHW-1:0]  remain_q;
   logic [SHW-1:0]  remain_d;
   logic [KW-1:0]   k_d;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            busy_q;
   logic            w_unused_rs2;

   assign w_unused_rs2 = ^rs2[XLEN-1:SHW];

   always_comb begin
      if (int'(remain_q) >= STEP) k_d = KW'(STEP);
      else                        k_d = KW'(remain_q);
   end

   assign remain_d = remain_q - SHW'(k_d);

   alu_shift_step #(
      .XLEN (XLEN),
      .STEP (STEP),
      .KW   (KW)
   ) u_step (
      .op_i   (op_q),
      .k_i    (k_d),
      .data_i (work_q),
      .data_o (work_d)
   );

   // rd_q is loaded only on entry to DONE so it holds its value everywhere else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= ALU_SLL;
         work_q      <= '0;
         rd_q        <= '0;
         remain_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q       <= op;
                  work_q     <= rs1;
                  remain_q   <= rs2[SHW-1:0];
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (rs2[SHW-1:0] == '0) begin
                     state_q     <= ST_DONE;
                     rd_q        <= rs1;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               work_q   <= work_d;
               remain_q <= remain_d;
               if (remain_d == '0) begin
                  state_q     <= ST_DONE;
                  rd_q        <= work_d;
                  out_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign rd        = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_shift_seq : drives STEP=4, STEP=1 and STEP=32 instances in lockstep
// Rev 1.0
// ============================================================================
module tb_alu_shift_seq;

   localparam int XLEN = 32;
   localparam int NI   = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            out_ready;
   logic [1:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            in_ready_a  [NI];
   logic            out_valid_a [NI];
   logic            busy_a      [NI];
   logic [XLEN-1:0] rd_a        [NI];

   int              n_checks = 0;
   int              n_fail   = 0;
   int              lat_r [NI];
   int              bsy_r [NI];
   logic [XLEN-1:0] rd_r  [NI];

   always #5 clk = ~clk;

   alu_shift_seq #(.XLEN(XLEN), .STEP(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
      .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid_a[0]),
      .out_ready(out_ready), .rd(rd_a[0]), .busy(busy_a[0]));

   alu_shift_seq #(.XLEN(XLEN), .STEP(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
      .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid_a[1]),
      .out_ready(out_ready), .rd(rd_a[1]), .busy(busy_a[1]));

   alu_shift_seq #(.XLEN(XLEN), .STEP(32)) u_dut_s32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[2]),
      .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid_a[2]),
      .out_ready(out_ready), .rd(rd_a[2]), .busy(busy_a[2]));

   function automatic int step_of(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 32;
      endcase
   endfunction

   // Whole-word shifts from the operation definitions; ROR via a doubled word.
   function automatic logic [XLEN-1:0] ref_shift(input logic [1:0] o,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      int         s;
      logic [63:0] d;
      s = int'(b[4:0]);
      d = {a, a} >> s;
      case (o)
         2'b00:   return a << s;
         2'b01:   return a >> s;
         2'b11:   return $signed(a) >>> s;
         default: return d[31:0];
      endcase
   endfunction

   function automatic int ref_lat(input logic [XLEN-1:0] b, input int step);
      int s;
      s = int'(b[4:0]);
      return 1 + (s + step - 1) / step;
   endfunction

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         ok = in_ready_a[0] && in_ready_a[1] && in_ready_a[2];
         if (!ok) begin
            @(posedge clk); #1;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: in_ready=%b%b%b required 111",
                  in_ready_a[0], in_ready_a[1], in_ready_a[2]);
      end
   endtask

   // One transaction with out_ready held high; records latency, busy cycles, rd.
   task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
      bit done [NI];
      bit fin;
      int c;
      wait_idle();
      out_ready = 1'b1;
      op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
      for (int i = 0; i < NI; i++) begin
         done[i] = 1'b0; lat_r[i] = -1; bsy_r[i] = 0; rd_r[i] = 'x;
      end
      c   = 1;
      fin = 1'b0;
      for (int t = 0; t < 100 && !fin; t++) begin
         fin = 1'b1;
         for (int i = 0; i < NI; i++) begin
            if (busy_a[i]) bsy_r[i]++;
            if (!done[i] && out_valid_a[i]) begin
               done[i] = 1'b1; lat_r[i] = c; rd_r[i] = rd_a[i];
            end
            if (!done[i] || busy_a[i]) fin = 1'b0;
         end
         if (!fin) begin
            @(posedge clk); #1; c++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      op = 2'b00; rs1 = 32'hDEAD_BEEF; rs2 = 32'd3;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (in_ready_a[i] !== 1'b1 || out_valid_a[i] !== 1'b0 ||
             busy_a[i] !== 1'b0 || rd_a[i] !== '0) begin
            n_fail++;
            $display("FAIL reset[%0d]: in_ready=%b out_valid=%b busy=%b rd=%h required 1 0 0 00000000",
                     i, in_ready_a[i], out_valid_a[i], busy_a[i], rd_a[i]);
         end
      end
      in_valid = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed(input string name, input logic [1:0] o,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [XLEN-1:0] exp_rd, input int exp_lat0);
      run_op(o, a, b);
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (rd_r[i] !== exp_rd || lat_r[i] != ref_lat(b, step_of(i))) begin
            n_fail++;
            $display("FAIL %s[%0d]: rd=%h lat=%0d required rd=%h lat=%0d",
                     name, i, rd_r[i], lat_r[i], exp_rd, ref_lat(b, step_of(i)));
         end
      end
      n_checks++;
      if (lat_r[0] != exp_lat0) begin
         n_fail++;
         $display("FAIL %s_lat4: lat=%0d required %0d", name, lat_r[0], exp_lat0);
      end
   endtask

   task automatic test_sra_sign();
      test_directed("sra_sign", 2'b11, 32'h8000_0000, 32'd1, 32'hC000_0000, 2);
      test_directed("srl_same", 2'b01, 32'h8000_0000, 32'd1, 32'h4000_0000, 2);
   endtask

   task automatic test_long_shift();
      int exp_lat [NI];
      exp_lat = '{9, 32, 2};
      run_op(2'b00, 32'd1, 32'd31);
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (rd_r[i] !== 32'h8000_0000 || lat_r[i] != exp_lat[i] || bsy_r[i] != exp_lat[i]) begin
            n_fail++;
            $display("FAIL long_shift[%0d]: rd=%h lat=%0d busy_cycles=%0d required rd=80000000 lat=%0d busy_cycles=%0d",
                     i, rd_r[i], lat_r[i], bsy_r[i], exp_lat[i], exp_lat[i]);
         end
      end
   endtask

   task automatic test_zero_masked();
      test_directed("zero_amt", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
      test_directed("masked33", 2'b01, 32'd4, 32'd33, 32'd2, 2);
      test_directed("sra_mask", 2'b11, 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFF0, 1);
   endtask

   task automatic test_rotate();
      test_directed("ror4", 2'b10, 32'h1, 32'd4, 32'h1000_0000, 2);
      test_directed("ror5", 2'b10, 32'h1, 32'd5, 32'h0800_0000, 3);
   endtask

   task automatic test_random();
      logic [1:0]      o;
      logic [XLEN-1:0] a, b, e;
      for (int n = 0; n < 40; n++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         e = ref_shift(o, a, b);
         run_op(o, a, b);
         for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rd_r[i] !== e || lat_r[i] != ref_lat(b, step_of(i)) ||
                bsy_r[i] != ref_lat(b, step_of(i))) begin
               n_fail++;
               $display("FAIL random[%0d] op=%0d rs1=%h rs2=%h: rd=%h lat=%0d busy=%0d required rd=%h lat=%0d",
                        i, o, a, b, rd_r[i], lat_r[i], bsy_r[i], e, ref_lat(b, step_of(i)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [XLEN-1:0] e;
      bit all_v;
      e = ref_shift(2'b01, 32'hF0F0_0F0F, 32'd7);
      wait_idle();
      out_ready = 1'b0;
      op = 2'b01; rs1 = 32'hF0F0_0F0F; rs2 = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      all_v = 1'b0;
      for (int t = 0; t < 100 && !all_v; t++) begin
         all_v = out_valid_a[0] && out_valid_a[1] && out_valid_a[2];
         if (!all_v) begin
            @(posedge clk); #1;
         end
      end
      n_checks++;
      if (!all_v) begin
         n_fail++;
         $display("FAIL bp_done_timeout: out_valid=%b%b%b required 111",
                  out_valid_a[0], out_valid_a[1], out_valid_a[2]);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; op = 2'b00; rs1 = $urandom; rs2 = 32'd3;
         @(posedge clk); #1;
         for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (rd_a[i] !== e || out_valid_a[i] !== 1'b1 || in_ready_a[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_hold[%0d] cyc %0d: rd=%h out_valid=%b in_ready=%b required rd=%h 1 0",
                        i, c, rd_a[i], out_valid_a[i], in_ready_a[i], e);
            end
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (in_ready_a[i] !== 1'b1 || out_valid_a[i] !== 1'b0 || busy_a[i] !== 1'b0 ||
             rd_a[i] !== e) begin
            n_fail++;
            $display("FAIL bp_release[%0d]: in_ready=%b out_valid=%b busy=%b rd=%h required 1 0 0 rd=%h",
                     i, in_ready_a[i], out_valid_a[i], busy_a[i], rd_a[i], e);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen_v;
      wait_idle();
      out_ready = 1'b1;
      op = 2'b00; rs1 = 32'd1; rs2 = 32'd31; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (in_ready_a[i] !== 1'b1 || out_valid_a[i] !== 1'b0 ||
             busy_a[i] !== 1'b0 || rd_a[i] !== '0) begin
            n_fail++;
            $display("FAIL reset_mid[%0d]: in_ready=%b out_valid=%b busy=%b rd=%h required 1 0 0 00000000",
                     i, in_ready_a[i], out_valid_a[i], busy_a[i], rd_a[i]);
         end
      end
      seen_v = 1'b0;
      for (int t = 0; t < 12; t++) begin
         @(posedge clk); #1;
         for (int i = 0; i < NI; i++) if (out_valid_a[i]) seen_v = 1'b1;
      end
      n_checks++;
      if (seen_v) begin
         n_fail++;
         $display("FAIL reset_mid_no_valid: out_valid pulse seen=1 required 0");
      end
      test_directed("after_reset", 2'b01, 32'd2, 32'd1, 32'd1, 2);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; rs1 = '0; rs2 = '0;
      test_reset();
      test_sra_sign();
      test_long_shift();
      test_zero_masked();
      test_rotate();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_shift_seq.md
# alu_shift_seq

Parametrised, multi-cycle shift unit that succeeds the single-cycle combinational `alu_sra`. It executes SLL, SRL, SRA and ROR on an `XLEN`-bit operand by shifting at most `STEP` bits per clock, trading latency for area. It sits beside the other ALU function units, accepting operands through a valid/ready handshake and holding its result until the consumer takes it.

## Interface
- `XLEN`, 32: operand/result width; power of 2, ≥ 8.
- `STEP`, 4: maximum bits shifted per cycle; power of 2, 1 ≤ `STEP` ≤ `XLEN`.
- `SHW`, log2(`XLEN`): shift-amount width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and op are valid.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `op`  in  2  operation: 00 SLL, 01 SRL, 10 ROR (rotate right), 11 SRA.
- `rs1`  in  `XLEN`  value to be shifted.
- `rs2`  in  `XLEN`  shift amount; only `rs2[SHW-1:0]` is used, upper bits ignored.
- `out_valid`  out  1  `rd` holds a finished result.
- `out_ready`  in  1  consumer takes the result.
- `rd`  out  `XLEN`  result.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch `op`, load the `rs1` working register, set `remain` = `rs2[SHW-1:0]`. Next state is DONE if `remain`==0, else SHIFT.
- SHIFT: each edge shifts the working register by k = min(`STEP`, `remain`) and sets `remain` −= k. The state moves to DONE on the edge where `remain` reaches 0.
- Per-step fill rules:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: copies of the current MSB enter at the MSB, which preserves the original sign.
  - ROR: bits leaving at the LSB re-enter at the MSB.
- DONE: `out_valid`=1 and `rd` = working register. When `out_ready`=1 the unit returns to IDLE on that edge. No accept happens in the same cycle as the result transfer.
- `rd` is stable while `out_valid`=1 and `out_ready`=0. It also holds its last value in IDLE.
- Inputs are ignored outside IDLE.
- Reset mid-operation: `rst` overrides everything; the operation in flight is discarded, with no `out_valid` pulse.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `rd`=0, `remain`=0.
- Latency, from accept edge to first cycle with `out_valid`=1: 1 + ceil(shamt/`STEP`) cycles.
  - shamt=0: 1 cycle.
  - `STEP`=4, shamt=31: 9 cycles.
- Minimum spacing between accepts: latency + 1 cycle, counting the transfer cycle.
- `STEP`=`XLEN`: every nonzero shift completes in one SHIFT cycle, i.e. latency 2.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- `alu_pkg`:
  - op encodings `ALU_SLL`=2'b00, `ALU_SRL`=2'b01, `ALU_ROR`=2'b10, `ALU_SRA`=2'b11.
  - FSM state encoding IDLE/SHIFT/DONE.
  - shared with future ALU units.
- Sub-module `alu_shift_step`:
  - combinational; shifts `XLEN` bits by k ∈ [0, `STEP`] per `op`.
  - a log2(`STEP`+1)-stage mux tree.
  - instantiated once; `alu_shift_seq` holds the FSM, `remain` counter and result register.

## Test plan
(Default parameters unless noted.)
1. SRA sign: `op`=11, `rs1`=0x80000000, `rs2`=1 → `rd`=0xC0000000 with latency 2. Then `op`=01 with the same operands → `rd`=0x40000000.
2. Long shift and count: `op`=00, `rs1`=1, `rs2`=31 → `rd`=0x80000000, latency exactly 9, `busy` high for 9 cycles. Repeat with `STEP`=1 → latency 32. Repeat with `STEP`=32 → latency 2.
3. Zero and masked amount:
   - `rs2`=0 → `rd`=`rs1`, latency 1.
   - `op`=01, `rs1`=4, `rs2`=33 → shamt 1, `rd`=2.
   - `op`=11, `rs1`=0xFFFFFFF0, `rs2`=0x20 → `rd`=0xFFFFFFF0.
4. Rotate: `op`=10, `rs1`=0x00000001, `rs2`=4 → `rd`=0x10000000. Then `rs2`=5 (split 4+1) → `rd`=0x08000000.
5. Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `rd` and `out_valid` stable, `in_ready`=0, and a new `in_valid` is ignored. Raise `out_ready` → IDLE next edge.
6. Reset mid-SHIFT: assert `rst` for one cycle during op 2 → next cycle state=IDLE, `rd`=0, no `out_valid`. A following `op`=01, `rs1`=2, `rs2`=1 returns 1.
